// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected layer datapath.
//   fx16_t           : signed Q8.8 activation word
//   FC_IN/HID/OUT    : layer sizes of the 120 -> 84 -> 10 network
//   FC_*_AW          : address widths needed to index each layer's vector
package fc_pkg;

    localparam int unsigned FC_DATA_W = 16;

    typedef logic signed [FC_DATA_W-1:0] fx16_t;

    localparam int unsigned FC_IN  = 120;
    localparam int unsigned FC_HID = 84;
    localparam int unsigned FC_OUT = 10;

    localparam int unsigned FC_IN_AW  = $clog2(FC_IN);
    localparam int unsigned FC_HID_AW = $clog2(FC_HID);
    localparam int unsigned FC_OUT_AW = $clog2(FC_OUT);

endpackage

// File: rtl/fc_act_ram.sv
// One activation bank: synchronous write port, registered read port.
// The read register only updates on i_rd_en, so its output holds between reads.
// Ports:
//   clk        : clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write index
//   i_wr_data  : write word
//   i_rd_en    : read strobe
//   i_rd_addr  : read index
//   o_rd_data  : registered read result (one cycle after i_rd_en)
module fc_act_ram
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W = FC_DATA_W,
    parameter int unsigned DEPTH  = FC_HID,
    parameter int unsigned ADDR_W = FC_HID_AW
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // Storage and read register are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_q <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/fc_act_buffer.sv
// Double-buffered activation stage between two FC layers. A streamed vector
// fills bank wsel while the reader owns bank rsel for random-access reads.
// Build option: define FC_ACT_RELU_EN to clamp negative words to zero on write;
// otherwise words are stored unchanged.
// Ports:
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : producer handshake
//   in_data, in_last    : neuron word and end-of-vector marker
//   rd_avail            : a completed bank is owned by the reader
//   rd_en, rd_addr      : read strobe and neuron index
//   rd_data, rd_valid   : read result, one cycle after rd_en
//   rd_release          : reader done with current bank
//   len_err             : sticky vector-length error
module fc_act_buffer
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W = FC_DATA_W,
    parameter int unsigned DEPTH  = FC_HID,
    parameter int unsigned ADDR_W = FC_HID_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              rd_avail,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_release,
    output logic              len_err
);

    logic [1:0]        r_full;
    logic              r_wsel;
    logic              r_rsel;
    logic [ADDR_W-1:0] r_wcnt;
    logic              r_len_err;
    logic              r_rd_valid;
    logic              r_rd_sel;
    logic              r_rd_oob;

    logic              w_accept;
    logic              w_at_end;
    logic              w_commit;
    logic              w_release;
    logic              w_rd_hit;
    logic              w_rd_oob;
    logic [1:0]        w_full_nxt;
    logic [1:0]        w_wr_en;
    logic [1:0]        w_rd_en;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_q0;
    logic [DATA_W-1:0] w_q1;

    assign in_ready  = ~r_full[r_wsel];
    assign rd_avail  = r_full[r_rsel];
    assign w_accept  = in_valid & in_ready;
    assign w_at_end  = (r_wcnt == ADDR_W'(DEPTH - 1));
    assign w_commit  = w_accept & w_at_end;
    assign w_release = rd_release & rd_avail;
    assign w_rd_hit  = rd_en & rd_avail;
    assign w_rd_oob  = (32'(rd_addr) >= DEPTH);

`ifdef FC_ACT_RELU_EN
    assign w_wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign w_wr_data = in_data;
`endif

    assign w_wr_en[0] = w_accept & ~r_wsel;
    assign w_wr_en[1] = w_accept &  r_wsel;
    // Reads always target the pre-release bank; out-of-range reads skip the RAM.
    assign w_rd_en[0] = w_rd_hit & ~w_rd_oob & ~r_rsel;
    assign w_rd_en[1] = w_rd_hit & ~w_rd_oob &  r_rsel;

    // Commit and release touch different banks, so both may apply at once.
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit)  w_full_nxt[r_wsel] = 1'b1;
        if (w_release) w_full_nxt[r_rsel] = 1'b0;
    end

    // Pointers, counter, flags and read-result select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= 2'b00;
            r_wsel     <= 1'b0;
            r_rsel     <= 1'b0;
            r_wcnt     <= '0;
            r_len_err  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_sel   <= 1'b0;
            // Out-of-range select forces rd_data to zero without resetting RAM.
            r_rd_oob   <= 1'b1;
        end else begin
            r_full     <= w_full_nxt;
            r_rd_valid <= w_rd_hit;
            if (w_accept) r_wcnt <= w_at_end ? '0 : r_wcnt + ADDR_W'(1);
            if (w_commit)  r_wsel <= ~r_wsel;
            if (w_release) r_rsel <= ~r_rsel;
            if (w_accept && (in_last != w_at_end)) r_len_err <= 1'b1;
            if (w_rd_hit) begin
                r_rd_sel <= r_rsel;
                r_rd_oob <= w_rd_oob;
            end
        end
    end

    fc_act_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk       (clk),
        .i_wr_en   (w_wr_en[0]),
        .i_wr_addr (r_wcnt),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en[0]),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_q0)
    );

    fc_act_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk       (clk),
        .i_wr_en   (w_wr_en[1]),
        .i_wr_addr (r_wcnt),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en[1]),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_q1)
    );

    assign rd_data  = r_rd_oob ? '0 : (r_rd_sel ? w_q1 : w_q0);
    assign rd_valid = r_rd_valid;
    assign len_err  = r_len_err;

endmodule

// File: tb/tb_fc_act_buffer.sv
// Scoreboard bench for fc_act_buffer: reads push expected words, a negedge
// monitor pops and compares whenever rd_valid is high.
module tb_fc_act_buffer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 84;
    localparam int unsigned ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              rd_avail;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_release = 1'b0;
    logic              len_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    fc_act_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .rd_avail   (rd_avail),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_release (rd_release),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    // Monitor: every valid read result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_unexpected: got rd_data=%h with no read pending", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_errors++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream words lo..hi; word i is base+i, or 0xFF00 at neg_idx.
    task automatic send_range(input logic [15:0] base, input int lo, input int hi,
                              input int neg_idx, input int last_idx);
        int budget;
        for (int i = lo; i <= hi; i++) begin
            in_valid = 1'b1;
            in_data  = (i == neg_idx) ? 16'hFF00 : base + 16'(i);
            in_last  = (i == last_idx);
            budget   = 0;
            while (!in_ready && budget < 500) begin
                tick();
                budget++;
            end
            if (!in_ready) begin
                n_checks++;
                n_errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 expected 1 at word %0d", i);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    logic [15:0] neg_exp;

    initial begin
`ifdef FC_ACT_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hFF00;
`endif
        tick();
        tick();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_rd_avail", 32'(rd_avail), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data",  32'(rd_data),  32'd0);
        chk("reset_len_err",  32'(len_err),  32'd0);
        rst = 1'b0;
        tick();

        // Vector 1: 0x0100..0x0153
        send_range(16'h0100, 0, 82, -1, 83);
        chk("v1_avail_before_last", 32'(rd_avail), 32'd0);
        send_range(16'h0100, 83, 83, -1, 83);
        chk("v1_avail", 32'(rd_avail), 32'd1);
        chk("v1_len_err", 32'(len_err), 32'd0);
        chk("v1_in_ready", 32'(in_ready), 32'd1);
        rd(5, 16'h0105);
        rd(0, 16'h0100);
        rd(100, 16'h0000);
        rd(83, 16'h0153);
        release_bank();
        chk("v1_released", 32'(rd_avail), 32'd0);
        // Read with nothing available: no valid, data holds 0x0153.
        rd_en = 1'b1;
        rd_addr = 7'd2;
        tick();
        rd_en = 1'b0;
        chk("noavail_rd_valid", 32'(rd_valid), 32'd0);
        chk("noavail_rd_hold", 32'(rd_data), 32'h0153);

        // Vector 2: negative word at index 3
        send_range(16'h0200, 0, 83, 3, 83);
        rd(3, neg_exp);
        rd(4, 16'h0204);
        release_bank();

        // Three vectors without release
        send_range(16'h0300, 0, 83, -1, 83);
        chk("a_in_ready", 32'(in_ready), 32'd1);
        send_range(16'h0400, 0, 83, -1, 83);
        chk("b_in_ready_stall", 32'(in_ready), 32'd0);
        rd(7, 16'h0307);
        // Read and release together: read sees vector A.
        rd_en = 1'b1;
        rd_addr = 7'd1;
        rd_release = 1'b1;
        exp_q.push_back(16'h0301);
        tick();
        rd_en = 1'b0;
        rd_release = 1'b0;
        chk("after_release_in_ready", 32'(in_ready), 32'd1);
        chk("after_release_avail", 32'(rd_avail), 32'd1);
        send_range(16'h0500, 0, 83, -1, 83);
        rd(2, 16'h0402);
        release_bank();
        rd(9, 16'h0509);
        release_bank();

        // Early in_last at word 10
        chk("pre_len_err", 32'(len_err), 32'd0);
        send_range(16'h0600, 0, 9, -1, 9);
        chk("early_last_len_err", 32'(len_err), 32'd1);
        chk("early_last_no_commit", 32'(rd_avail), 32'd0);
        send_range(16'h0600, 10, 83, -1, 9);
        chk("count_commit_avail", 32'(rd_avail), 32'd1);
        chk("len_err_sticky", 32'(len_err), 32'd1);
        rd(50, 16'h0632);

        // Reset with one bank full and 40 words into the other
        send_range(16'h0700, 0, 39, -1, 83);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rd_avail", 32'(rd_avail), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        chk("rst_len_err",  32'(len_err),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_range(16'h0800, 0, 83, -1, 83);
        chk("post_rst_avail", 32'(rd_avail), 32'd1);
        rd(0, 16'h0800);
        rd(40, 16'h0828);
        rd(83, 16'h0853);
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fc_act_buffer.md
# fc_act_buffer

Double-buffered activation stage between two fully-connected layers. It accepts the streamed 16-bit neuron outputs of one layer, optionally applies ReLU, and stores them in one of two banks. It then serves random-access reads of a completed vector to the next layer while the other bank fills. It sits directly downstream of the FC layer (84-neuron hidden layer → 10-class output layer).

## Interface
Parameters:
- DATA_W, 16: activation width, signed Q8.8
- DEPTH, 84: neurons per vector
- ADDR_W, 7: read-address width, must satisfy 2**ADDR_W ≥ DEPTH

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer word valid
- in_ready  output  1  buffer can accept a word
- in_data  input  DATA_W  signed neuron output
- in_last  input  1  producer marks the final word of a vector
- rd_avail  output  1  a completed bank is owned by the reader
- rd_en  input  1  read strobe
- rd_addr  input  ADDR_W  neuron index
- rd_data  output  DATA_W  read result
- rd_valid  output  1  rd_data valid this cycle
- rd_release  input  1  one-cycle pulse: reader has finished with the current bank
- len_err  output  1  sticky vector-length error

## Operation
- State: two banks (b0, b1), full[1:0], write-bank pointer wsel, read-bank pointer rsel, word counter wcnt (0..DEPTH-1).
- in_ready = !full[wsel]. A word is accepted on a clk edge with in_valid && in_ready. It is written to bank wsel at wcnt, and wcnt increments.
- Commit: on acceptance with wcnt == DEPTH-1, full[wsel] is set, wsel toggles, and wcnt is cleared. A commit is triggered by the count alone.
- len_err is set, and stays set until rst, in two cases: in_last is accepted with wcnt ≠ DEPTH-1, or the word at wcnt == DEPTH-1 is accepted without in_last. A word accepted with in_last early does not commit; counting continues.
- rd_avail = full[rsel].
- rd_release with rd_avail: full[rsel] clears and rsel toggles. rd_release without rd_avail is ignored.
- Commit of one bank and release of the other in the same cycle: both take effect.
- A read hits bank rsel. rd_en with rd_addr ≥ DEPTH returns 0 with rd_valid=1. rd_en while !rd_avail gives rd_valid=0, and rd_data holds.
- rd_data holds its last value when no valid read occurs.
- Arithmetic: values are stored as DATA_W signed. There is no widening or rounding; ReLU is the only transform.

## Timing
- Reset values: in_ready=1, rd_avail=0, rd_valid=0, rd_data=0, len_err=0, full=0, wsel=0, rsel=0, wcnt=0. Bank contents are not reset.
- rst mid-vector discards the partial vector and any committed banks.
- rd_avail rises one cycle after the edge that accepts word DEPTH-1.
- Read latency is 1 cycle: rd_en/rd_addr sampled at edge N produce rd_data/rd_valid after edge N, for one cycle.
- Back-to-back vectors: in_ready stays 1 across a commit if the other bank is empty, so there is zero bubble.
- With both banks full, in_ready=0 until the cycle after rd_release.
- rd_release and rd_en in the same cycle: the read uses the pre-release bank.

## Configuration
- FC_ACT_RELU_EN defined: a stored word is 0 if in_data is negative, otherwise in_data.
- FC_ACT_RELU_EN undefined: in_data is stored unchanged (linear output layer).
- Nothing else changes with the macro.

## Structure
- Shared package fc_pkg holds:
  - fx16_t (signed 16-bit Q8.8)
  - layer-size constants FC_IN=120, FC_HID=84, FC_OUT=10
  - the derived address widths
- Sub-module fc_act_ram: one bank, synchronous write port and registered read port, DEPTH × DATA_W. It is instantiated twice; the top holds the pointers, counters and handshake logic.

## Test plan
- Stream 84 words 0x0100..0x0153 with in_last on word 84 → rd_avail=1 one cycle later; reading addr 5 returns 0x0105 one cycle after rd_en; len_err=0.
- Stream a vector containing 0xFF00 at index 3 → with FC_ACT_RELU_EN, addr 3 reads 0x0000; without it, reads 0xFF00.
- Stream three vectors without any rd_release → in_ready drops after the second commit; the third vector stalls until rd_release, then completes; reads show vector 2 data after release.
- Assert in_last on word 10 → len_err=1 and no commit; the remaining 74 words still commit the bank at count 84.
- rd_addr=100 with rd_avail → rd_data=0, rd_valid=1. rd_en with rd_avail=0 → rd_valid=0.
- Assert rst after 40 words of a vector and with one bank full → all outputs at reset values; the next 84-word vector commits to bank 0 and is read correctly.
